// File: rtl/logicunit_bist.sv
// Built-in self-test for the combinational logicunit: sweeps every (A, B, control)
// vector once per start, checks the returned out against a golden model and records the results.
module logicunit_bist #(
   parameter int W = 1,
   localparam int CW = 2*W+2
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic [W-1:0]  lu_out,
   output logic [W-1:0]  lu_A,
   output logic [W-1:0]  lu_B,
   output logic [1:0]    lu_control,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [CW:0]   fail_count,
   output logic [CW-1:0] first_fail
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] idx;
   logic [W-1:0]  expected;
   logic          mismatch;
   logic          last_vec;
   logic          launch;

   function automatic logic [W-1:0] golden(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [1:0]   op);
      logic [W-1:0] r;
      case (op)
         2'd0:    r = a & b;
         2'd1:    r = a | b;
         2'd2:    r = ~(a | b);
         default: r = a ^ b;
      endcase
      return r;
   endfunction

   assign last_vec = &idx;
   assign launch   = start && (state == IDLE || state == DONE);
   assign expected = golden(idx[W-1:0], idx[2*W-1:W], idx[2*W+1:2*W]);

   // An X on lu_out falls through to the mismatch default rather than matching.
   always_comb begin
      mismatch = 1'b1;
      if (lu_out == expected)
         mismatch = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_vec) state_nxt = DONE;
         DONE:    if (start) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy       = 1'b0;
      done       = 1'b0;
      lu_A       = '0;
      lu_B       = '0;
      lu_control = 2'b00;
      case (state)
         RUN: begin
            busy       = 1'b1;
            lu_A       = idx[W-1:0];
            lu_B       = idx[2*W-1:W];
            lu_control = idx[2*W+1:2*W];
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   assign pass = done && (fail_count == '0);

   // Vector idx is checked on the edge that ends its RUN cycle; idx holds at N-1 after the sweep.
   always_ff @(posedge clock) begin
      if (reset) begin
         idx        <= '0;
         fail_count <= '0;
         first_fail <= '0;
      end else if (launch) begin
         idx        <= '0;
         fail_count <= '0;
         first_fail <= '0;
      end else if (state == RUN) begin
         if (mismatch) begin
            fail_count <= fail_count + (CW+1)'(1);
            if (fail_count == '0)
               first_fail <= idx;
         end
         if (!last_vec)
            idx <= idx + CW'(1);
      end
   end

endmodule

// File: tb/tb_logicunit_bist.sv
// Scoreboard bench for logicunit_bist: W=1 and W=2 instances, each beside a logicunit model
// whose fault can be selected; sweep results are queued at start and checked when done rises.
module tb_logicunit_bist;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start1 = 1'b0;
   logic       start2 = 1'b0;

   logic [0:0] out1, a1, b1;
   logic [1:0] ctl1;
   logic       busy1, done1, pass1;
   logic [4:0] fc1;
   logic [3:0] ff1;

   logic [1:0] out2, a2, b2;
   logic [1:0] ctl2;
   logic       busy2, done2, pass2;
   logic [6:0] fc2;
   logic [5:0] ff2;

   int fault1 = 0;
   int fault2 = 0;

   int tests  = 0;
   int errors = 0;

   typedef struct {
      int fc;
      int ff;
      int ps;
      int cyc;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];

   always #5 clock = ~clock;

   logicunit_bist #(.W(1)) u1 (
      .clock(clock), .reset(reset), .start(start1), .lu_out(out1),
      .lu_A(a1), .lu_B(b1), .lu_control(ctl1),
      .busy(busy1), .done(done1), .pass(pass1),
      .fail_count(fc1), .first_fail(ff1)
   );

   logicunit_bist #(.W(2)) u2 (
      .clock(clock), .reset(reset), .start(start2), .lu_out(out2),
      .lu_A(a2), .lu_B(b2), .lu_control(ctl2),
      .busy(busy2), .done(done2), .pass(pass2),
      .fail_count(fc2), .first_fail(ff2)
   );

   // fault: 0 = correct, 1 = control 3 computes XNOR, 2 = output stuck at 0
   function automatic logic [3:0] lu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] c, input int fault);
      logic [3:0] r;
      if (fault == 2) return 4'b0000;
      case (c)
         2'd0: r = a & b;
         2'd1: r = a | b;
         2'd2: r = ~(a | b);
         default: r = (fault == 1) ? ~(a ^ b) : (a ^ b);
      endcase
      return r;
   endfunction

   logic [3:0] m1, m2;
   always_comb begin
      m1   = lu_model({3'b000, a1}, {3'b000, b1}, ctl1, fault1);
      out1 = m1[0:0];
      m2   = lu_model({2'b00, a2}, {2'b00, b2}, ctl2, fault2);
      out2 = m2[1:0];
   end

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Monitors: operands follow the cycle index while busy, are zero otherwise; results on done rise.
   int  cnt1 = 0, cnt2 = 0;
   logic done1_q = 1'b0, done2_q = 1'b0;

   always @(negedge clock) begin
      exp_t e;
      if (reset) begin
         cnt1 = 0;
      end else begin
         if (busy1) begin
            check("u1_operands", int'({ctl1, b1, a1}), cnt1);
            cnt1++;
         end else
            check("u1_idle_operands", int'({ctl1, b1, a1}), 0);
         if (done1 && !done1_q) begin
            if (q1.size() == 0)
               check("u1_unexpected_done", 1, 0);
            else begin
               e = q1.pop_front();
               check("u1_fail_count", int'(fc1), e.fc);
               check("u1_first_fail", int'(ff1), e.ff);
               check("u1_pass", int'(pass1), e.ps);
               check("u1_busy_cycles", cnt1, e.cyc);
            end
            cnt1 = 0;
         end
      end
      done1_q = done1;
   end

   always @(negedge clock) begin
      exp_t e;
      if (reset) begin
         cnt2 = 0;
      end else begin
         if (busy2) begin
            check("u2_operands", int'({ctl2, b2, a2}), cnt2);
            cnt2++;
         end else
            check("u2_idle_operands", int'({ctl2, b2, a2}), 0);
         if (done2 && !done2_q) begin
            if (q2.size() == 0)
               check("u2_unexpected_done", 1, 0);
            else begin
               e = q2.pop_front();
               check("u2_fail_count", int'(fc2), e.fc);
               check("u2_first_fail", int'(ff2), e.ff);
               check("u2_pass", int'(pass2), e.ps);
               check("u2_busy_cycles", cnt2, e.cyc);
            end
            cnt2 = 0;
         end
      end
      done2_q = done2;
   end

   task automatic push1(input int fc, input int ff, input int ps);
      exp_t e;
      e.fc = fc; e.ff = ff; e.ps = ps; e.cyc = 16;
      q1.push_back(e);
   endtask

   task automatic push2(input int fc, input int ff, input int ps);
      exp_t e;
      e.fc = fc; e.ff = ff; e.ps = ps; e.cyc = 64;
      q2.push_back(e);
   endtask

   task automatic pulse_start1();
      @(posedge clock); #1 start1 = 1'b1;
      @(posedge clock); #1 start1 = 1'b0;
   endtask

   task automatic wait_done1(input int budget);
      int n = 0;
      while (!done1 && n < budget) begin
         @(posedge clock); #1;
         n++;
      end
      check("u1_done_timeout", int'(done1), 1);
      @(negedge clock); #1;
   endtask

   task automatic wait_done2(input int budget);
      int n = 0;
      while (!done2 && n < budget) begin
         @(posedge clock); #1;
         n++;
      end
      check("u2_done_timeout", int'(done2), 1);
      @(negedge clock); #1;
   endtask

   task automatic check_all_zero1(input string tag);
      check({tag, "_busy"}, int'(busy1), 0);
      check({tag, "_done"}, int'(done1), 0);
      check({tag, "_pass"}, int'(pass1), 0);
      check({tag, "_fail_count"}, int'(fc1), 0);
      check({tag, "_first_fail"}, int'(ff1), 0);
      check({tag, "_operands"}, int'({ctl1, b1, a1}), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      check_all_zero1("reset_u1");
      check("reset_u2_busy", int'(busy2), 0);
      check("reset_u2_fail_count", int'(fc2), 0);

      // Golden-correct W=1 sweep
      fault1 = 0; push1(0, 0, 1);
      pulse_start1();
      wait_done1(40);

      // XNOR on control 3: vectors 12..15 fail
      fault1 = 1; push1(4, 12, 0);
      pulse_start1();
      wait_done1(40);

      // Stuck-at-0 with a second start pulse at RUN cycle 5
      fault1 = 2; push1(7, 3, 0);
      pulse_start1();
      repeat (5) @(posedge clock);
      #1 start1 = 1'b1;
      @(posedge clock); #1 start1 = 1'b0;
      wait_done1(40);

      // Start from DONE with a correct model clears counters on the launch edge
      fault1 = 0; push1(0, 0, 1);
      pulse_start1();
      check("restart_fail_count", int'(fc1), 0);
      check("restart_first_fail", int'(ff1), 0);
      check("restart_busy", int'(busy1), 1);
      check("restart_done", int'(done1), 0);
      wait_done1(40);

      // Reset at RUN cycle 8 during a stuck-at-0 sweep
      fault1 = 2;
      pulse_start1();
      repeat (8) @(posedge clock);
      #1;
      check("mid_sweep_fail_count", int'(fc1), 4);
      check("mid_sweep_first_fail", int'(ff1), 3);
      reset = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      check_all_zero1("mid_reset");
      push1(7, 3, 0);
      pulse_start1();
      wait_done1(40);

      // Reset and start together: reset wins
      @(posedge clock); #1 reset = 1'b1; start1 = 1'b1;
      @(posedge clock); #1 reset = 1'b0; start1 = 1'b0;
      check_all_zero1("reset_vs_start");

      // W=2 correct model, twice; second run launched from DONE
      fault2 = 0;
      push2(0, 0, 1);
      @(posedge clock); #1 start2 = 1'b1;
      @(posedge clock); #1 start2 = 1'b0;
      wait_done2(100);
      push2(0, 0, 1);
      @(posedge clock); #1 start2 = 1'b1;
      @(posedge clock); #1 start2 = 1'b0;
      check("u2_restart_busy", int'(busy2), 1);
      check("u2_restart_fail_count", int'(fc2), 0);
      wait_done2(100);

      repeat (2) @(posedge clock);
      #1;
      check("u1_queue_drained", q1.size(), 0);
      check("u2_queue_drained", q2.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
